// File: rtl/segway_pkg.sv
// Shared types and constants for the balance controller.
// Rider sequencer states, timer widths and weight thresholds.
package segway_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } steer_state_t;

  localparam int TMR_W_FAST = 15;
  localparam int TMR_W_SLOW = 26;

  localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
  localparam logic [11:0] WT_HYST_DEF      = 12'h040;

endpackage

// File: rtl/settle_tmr.sv
// Saturating settle timer for the rider sequencer.
// Clear wins over increment; count never wraps.
module settle_tmr #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic         full,
  output logic [W-1:0] count
);

  assign full = &count;

  // Count clean cycles, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && !full)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/rider_steer_seq.sv
// Rider presence and steering enable sequencer.
// Captures loads, applies hysteresis, gates steering.
module rider_steer_seq
  import segway_pkg::*;
#(
  parameter bit          fast_sim     = 1'b1,
  parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
  parameter logic [11:0] WT_HYST      = WT_HYST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwr_up,
  input  logic        ld_vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic        rider_off,
  output logic        en_steer
);

  localparam int TMR_W = fast_sim ? TMR_W_FAST : TMR_W_SLOW;

  localparam logic [12:0] ON_TH  = {1'b0, MIN_RIDER_WT};
  localparam logic [12:0] OFF_TH = ON_TH - {1'b0, WT_HYST};

  steer_state_t state;

  logic [11:0]      lft_q;
  logic [11:0]      rght_q;
  logic             on_q;
  logic             on_nxt;
  logic [12:0]      sum;
  logic [11:0]      diff;
  logic             settle_bad;
  logic             steer_bad;
  logic             tmr_clr;
  logic             tmr_inc;
  logic             tmr_full;
  logic [TMR_W-1:0] tmr_cnt;

  assign sum  = {1'b0, lft_q} + {1'b0, rght_q};
  assign diff = (lft_q >= rght_q) ? (lft_q - rght_q)
                                  : (rght_q - lft_q);

  assign settle_bad = {1'b0, diff} > (sum >> 2);
  assign steer_bad  = {1'b0, diff} > (sum >> 1);

  // Hysteresis: set above threshold, clear below it.
  always_comb begin
    on_nxt = on_q;
    if (sum > ON_TH)
      on_nxt = 1'b1;
    else if (sum < OFF_TH)
      on_nxt = 1'b0;
  end

  // Only a clean, powered WAIT cycle short of full counts.
  always_comb begin
    tmr_inc = pwr_up && (state == WAIT) && on_q &&
              !settle_bad && !tmr_full;
    tmr_clr = !tmr_inc;
    if (pwr_up && (state == WAIT) && on_q &&
        !settle_bad && tmr_full)
      tmr_clr = 1'b1;
  end

  // Load capture and rider flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_q     <= '0;
      rght_q    <= '0;
      on_q      <= 1'b0;
      rider_off <= 1'b1;
    end else begin
      if (ld_vld) begin
        lft_q  <= lft_ld;
        rght_q <= rght_ld;
      end
      on_q      <= on_nxt;
      rider_off <= ~on_nxt;
    end
  end

  // Sequencer FSM with registered steering enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      en_steer <= 1'b0;
    end else if (!pwr_up) begin
      state    <= IDLE;
      en_steer <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (on_q)
            state <= WAIT;
          en_steer <= 1'b0;
        end
        WAIT: begin
          if (!on_q) begin
            state    <= IDLE;
            en_steer <= 1'b0;
          end else if (!settle_bad && tmr_full) begin
            state    <= STEER;
            en_steer <= 1'b1;
          end else begin
            en_steer <= 1'b0;
          end
        end
        STEER: begin
          if (!on_q) begin
            state    <= IDLE;
            en_steer <= 1'b0;
          end else if (steer_bad) begin
            state    <= WAIT;
            en_steer <= 1'b0;
          end else begin
            en_steer <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          en_steer <= 1'b0;
        end
      endcase
    end
  end

  settle_tmr #(.W(TMR_W)) u_tmr (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .full  (tmr_full),
    .count (tmr_cnt)
  );

endmodule
